// File: rtl/mul_div_unit_pkg.sv
// Shared opcodes, latency defaults and decode helpers for the HI/LO multiply/divide unit.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    MT_DISABLED          = 4'd0,
    MT_MULTIPLY          = 4'd1,
    MT_MULTIPLY_UNSIGNED = 4'd2,
    MT_DIVIDE            = 4'd3,
    MT_DIVIDE_UNSIGNED   = 4'd4,
    MT_SET_HI            = 4'd5,
    MT_SET_LO            = 4'd6,
    MT_MADD              = 4'd7,
    MT_MADDU             = 4'd8,
    MT_MSUB              = 4'd9
  } mt_op_e;

  localparam int unsigned MUL_CYCLES_DEFAULT = 5;
  localparam int unsigned DIV_CYCLES_DEFAULT = 10;

  // Writeback-source select used by the register-file mux for mfhi/mflo.
  localparam logic [1:0] GRF_WRITE_MUL = 2'd2;

  function automatic logic is_mul_op(input logic [3:0] ctrl);
    return ctrl inside {MT_MULTIPLY, MT_MULTIPLY_UNSIGNED, MT_MADD, MT_MADDU, MT_MSUB};
  endfunction

  function automatic logic is_div_op(input logic [3:0] ctrl);
    return ctrl inside {MT_DIVIDE, MT_DIVIDE_UNSIGNED};
  endfunction

endpackage

// File: rtl/mul_div_unit_compute.sv
// Purely combinational datapath: the 64-bit {hi,lo} an operation will commit, plus divide-by-zero.
module mdu_compute
  import mul_div_unit_pkg::*;
(
  input  logic [3:0]  ctrl,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] next_hilo,
  output logic        divByZero
);

  logic [63:0] hilo;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;

  assign hilo   = {hi, lo};
  assign prod_s = {{32{opA[31]}}, opA} * {{32{opB[31]}}, opB};
  assign prod_u = {32'd0, opA} * {32'd0, opB};

  // Signed divide runs on magnitudes through one unsigned divider; 0x80000000 / -1
  // falls out naturally as quotient 0x80000000, remainder 0.
  assign signed_div = (ctrl == MT_DIVIDE);
  assign neg_a      = signed_div & opA[31];
  assign neg_b      = signed_div & opB[31];
  assign mag_a      = neg_a ? (~opA + 32'd1) : opA;
  assign mag_b      = neg_b ? (~opB + 32'd1) : opB;
  assign divisor    = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign uq         = mag_a / divisor;
  assign ur         = mag_a % divisor;
  assign quot       = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
  assign rem        = neg_a ? (~ur + 32'd1) : ur;

  assign divByZero  = is_div_op(ctrl) && (opB == 32'd0);

  // NOTE: next_hilo gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_hilo = hilo;
    case (ctrl)
      MT_MULTIPLY:          next_hilo = prod_s;
      MT_MULTIPLY_UNSIGNED: next_hilo = prod_u;
      MT_MADD:              next_hilo = hilo + prod_s;
      MT_MADDU:             next_hilo = hilo + prod_u;
      MT_MSUB:              next_hilo = hilo - prod_s;
      MT_DIVIDE,
      MT_DIVIDE_UNSIGNED:   next_hilo = {rem, quot};
      default:              next_hilo = hilo;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage HI/LO unit: accept logic, fixed-latency busy counter and architectural HI/LO.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mulCtrl,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        outputSel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

  logic [63:0] pending;
  logic [63:0] next_hilo;
  logic [3:0]  count;
  logic        div_by_zero;
  logic        accept;

  mdu_compute u_compute (
    .ctrl      (mulCtrl),
    .opA       (opA),
    .opB       (opB),
    .hi        (hi),
    .lo        (lo),
    .next_hilo (next_hilo),
    .divByZero (div_by_zero)
  );

  // Anything arriving while busy is dropped; the hazard unit should never send it.
  assign accept = start && !cancel && !busy;
  assign result = outputSel ? hi : lo;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      pending <= 64'd0;
      count   <= 4'd0;
      busy    <= 1'b0;
    end else if (accept) begin
      if (mulCtrl == MT_SET_HI) begin
        hi <= opA;
      end else if (mulCtrl == MT_SET_LO) begin
        lo <= opA;
      end else if (is_mul_op(mulCtrl)) begin
        pending <= next_hilo;
        count   <= MUL_LOAD;
        busy    <= 1'b1;
      end else if (is_div_op(mulCtrl)) begin
        pending <= div_by_zero ? {hi, lo} : next_hilo;
        count   <= DIV_LOAD;
        busy    <= 1'b1;
      end
    end else if (busy) begin
      count <= count - 4'd1;
      if (count == 4'd1) begin
        hi   <= pending[63:32];
        lo   <= pending[31:0];
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: timestamp-based reference model checked every cycle plus literal pins.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  mulCtrl = 4'd0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] opA = 32'd0;
  logic [31:0] opB = 32'd0;
  logic        outputSel = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .mulCtrl   (mulCtrl),
    .start     (start),
    .cancel    (cancel),
    .opA       (opA),
    .opB       (opB),
    .outputSel (outputSel),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .result    (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: results computed from plain arithmetic, committed at an absolute edge index.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic        m_busy = 1'b0;
  logic [63:0] m_pending = 64'd0;
  int          cyc = 0;
  int          m_done = 0;

  function automatic int model_latency(input logic [3:0] op);
    if (op inside {MT_MULTIPLY, MT_MULTIPLY_UNSIGNED, MT_MADD, MT_MADDU, MT_MSUB}) return 5;
    if (op inside {MT_DIVIDE, MT_DIVIDE_UNSIGNED}) return 10;
    return 0;
  endfunction

  function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] hl);
    int          sa;
    int          sb;
    longint      sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    sp = longint'(sa) * longint'(sb);
    up = {32'd0, a} * {32'd0, b};
    case (op)
      MT_MULTIPLY:          return sp;
      MT_MULTIPLY_UNSIGNED: return up;
      MT_MADD:              return hl + sp;
      MT_MADDU:             return hl + up;
      MT_MSUB:              return hl - sp;
      MT_DIVIDE: begin
        if (b == 32'd0) return hl;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      MT_DIVIDE_UNSIGNED: begin
        if (b == 32'd0) return hl;
        return {a % b, a / b};
      end
      default: return hl;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi      <= 32'd0;
      m_lo      <= 32'd0;
      m_busy    <= 1'b0;
      m_pending <= 64'd0;
      cyc       <= 0;
      m_done    <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy) begin
        if (cyc + 1 == m_done) begin
          m_hi   <= m_pending[63:32];
          m_lo   <= m_pending[31:0];
          m_busy <= 1'b0;
        end
      end else if (start && !cancel) begin
        if (mulCtrl == MT_SET_HI) m_hi <= opA;
        else if (mulCtrl == MT_SET_LO) m_lo <= opA;
        else if (model_latency(mulCtrl) > 0) begin
          m_pending <= model_result(mulCtrl, opA, opB, {m_hi, m_lo});
          m_done    <= cyc + 1 + model_latency(mulCtrl);
          m_busy    <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
    check("cyc_hi", hi, m_hi);
    check("cyc_lo", lo, m_lo);
    check("cyc_result", result, outputSel ? m_hi : m_lo);
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    mulCtrl = op;
    opA     = a;
    opB     = b;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    mulCtrl = MT_DISABLED;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy !== 1'b0 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (cycles >= 40) begin
      n_vec++;
      n_err++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles, expected 0", busy, cycles);
    end
  endtask

  task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
  endtask

  initial begin
    int n;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_hilo("reset", 32'd0, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    issue(MT_MULTIPLY, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy_after_accept", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("mult_latency", n, 32'd5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    outputSel = 1'b1; #1;
    check("mult_result_hi", result, 32'hFFFF_FFFF);
    outputSel = 1'b0; #1;
    check("mult_result_lo", result, 32'hFFFF_FFFA);

    issue(MT_MULTIPLY_UNSIGNED, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("multu_latency", n, 32'd5);
    check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    issue(MT_DIVIDE, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_latency", n, 32'd10);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(MT_DIVIDE_UNSIGNED, 32'd7, 32'd0);
    wait_idle(n);
    check("divu0_latency", n, 32'd10);
    check_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(MT_SET_LO, 32'hFFFF_FFFF, 32'd0);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    issue(MT_SET_HI, 32'h0000_1234, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check_hilo("mt", 32'h0000_1234, 32'hFFFF_FFFF);

    issue(MT_MADD, 32'd2, 32'd3);
    wait_idle(n);
    check("madd_latency", n, 32'd5);
    check_hilo("madd", 32'h0000_1235, 32'h0000_0005);
    issue(MT_MSUB, 32'd2, 32'd3);
    wait_idle(n);
    check_hilo("msub", 32'h0000_1234, 32'hFFFF_FFFF);

    issue(MT_DIVIDE, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);

    issue(MT_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    check_hilo("maddu", 32'hFFFF_FFFE, 32'h8000_0001);

    // Cancelled start and unlisted codes must leave everything alone.
    @(posedge clk); #1;
    mulCtrl = MT_MULTIPLY; opA = 32'd5; opB = 32'd7; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; mulCtrl = MT_DISABLED;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    issue(4'hF, 32'd1, 32'd1);
    issue(MT_DISABLED, 32'd1, 32'd1);
    check("unlisted_busy", {31'd0, busy}, 32'd0);
    check_hilo("noop", 32'hFFFF_FFFE, 32'h8000_0001);

    // Starts and a cancel during busy: in-flight multiply still commits.
    issue(MT_MULTIPLY, 32'd2, 32'd3);
    mulCtrl = MT_SET_HI; opA = 32'h0000_DEAD; start = 1'b1;
    @(posedge clk); #1;
    mulCtrl = MT_MULTIPLY; opA = 32'd9; opB = 32'd9; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; mulCtrl = MT_DISABLED;
    wait_idle(n);
    check("busy_start_latency", n, 32'd3);
    check_hilo("busy_start", 32'd0, 32'd6);

    // Reset during busy cycle 3 of a divide aborts it with no late commit.
    issue(MT_SET_HI, 32'h0000_AAAA, 32'd0);
    issue(MT_DIVIDE, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_hilo("rst_mid", 32'd0, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check_hilo("rst_after", 32'd0, 32'd0);
    check("rst_after_busy", {31'd0, busy}, 32'd0);

    issue(MT_DIVIDE_UNSIGNED, 32'd100, 32'd7);
    wait_idle(n);
    check("divu_latency", n, 32'd10);
    check_hilo("divu", 32'd2, 32'd14);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
